rs_scheduler: RTL and testbench

- Reservation-station scheduler that owns the single integer execute unit (ALU/branch EX stage) and decides which waiting instruction uses it each cycle.
- Buffers dispatched ALU/branch/jump µops and snoops the CDB (EX and LSB result buses) to wake waiting operands.
- Issues at most one ready µop per cycle to EX through registered outputs.
- Sits between the decoder/dispatch stage and EX; ROB receives the results from EX.

---
 rtl/rs_scheduler_pkg.sv | 19 +
 rtl/rs_prio_enc.sv | 23 ++
 rtl/rs_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_rs_scheduler.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_scheduler_pkg.sv
// Shared widths, sizes and instruction-id constants for the reservation station.
package rs_scheduler_pkg;

  localparam int RS_SIZE    = 8;
  localparam int ROB_IDX_W  = 4;
  localparam int INSTR_ID_W = 6;
  localparam int WORD_W     = 32;

  // Instruction ids understood by the EX stage.
  localparam logic [INSTR_ID_W-1:0] ID_LUI   = 6'd1;
  localparam logic [INSTR_ID_W-1:0] ID_AUIPC = 6'd2;
  localparam logic [INSTR_ID_W-1:0] ID_JAL   = 6'd3;
  localparam logic [INSTR_ID_W-1:0] ID_JALR  = 6'd4;
  localparam logic [INSTR_ID_W-1:0] ID_BEQ   = 6'd5;
  localparam logic [INSTR_ID_W-1:0] ID_BNE   = 6'd6;
  localparam logic [INSTR_ID_W-1:0] ID_ADDI  = 6'd19;
  localparam logic [INSTR_ID_W-1:0] ID_ADD   = 6'd28;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-set priority encoder with a found flag.
module rs_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_in,
  output logic [IDX_W-1:0] idx_out,
  output logic             found_out
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_out   = '0;
    found_out = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        idx_out   = IDX_W'(i);
        found_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation station owning the integer EX unit: buffers dispatched uops,
// wakes operands from the EX/LSB result buses, issues one ready uop per cycle.
module rs_scheduler #(
  parameter int RS_SIZE    = rs_scheduler_pkg::RS_SIZE,
  parameter int ROB_IDX_W  = rs_scheduler_pkg::ROB_IDX_W,
  parameter int INSTR_ID_W = rs_scheduler_pkg::INSTR_ID_W,
  parameter int WORD_W     = rs_scheduler_pkg::WORD_W
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  disp_en_in,
  input  logic [INSTR_ID_W-1:0] disp_instr_id_in,
  input  logic [WORD_W-1:0]     disp_imm_in,
  input  logic [WORD_W-1:0]     disp_pc_in,
  input  logic [ROB_IDX_W-1:0]  disp_rob_pos_in,
  input  logic [WORD_W-1:0]     disp_vj_in,
  input  logic [WORD_W-1:0]     disp_vk_in,
  input  logic [ROB_IDX_W-1:0]  disp_qj_in,
  input  logic [ROB_IDX_W-1:0]  disp_qk_in,
  input  logic                  disp_j_busy_in,
  input  logic                  disp_k_busy_in,
  output logic                  full_out,
  input  logic                  ex_cdb_en_in,
  input  logic [ROB_IDX_W-1:0]  ex_cdb_rob_pos_in,
  input  logic [WORD_W-1:0]     ex_cdb_res_in,
  input  logic                  lsb_cdb_en_in,
  input  logic [ROB_IDX_W-1:0]  lsb_cdb_rob_pos_in,
  input  logic [WORD_W-1:0]     lsb_cdb_res_in,
  output logic                  rs_to_ex_en_out,
  output logic [INSTR_ID_W-1:0] ex_instr_id_out,
  output logic [WORD_W-1:0]     ex_imm_out,
  output logic [WORD_W-1:0]     ex_rs1_out,
  output logic [WORD_W-1:0]     ex_rs2_out,
  output logic [WORD_W-1:0]     ex_pc_out,
  output logic [ROB_IDX_W-1:0]  ex_rob_pos_out
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Entry storage
  logic [RS_SIZE-1:0]    valid_q, valid_d;
  logic [RS_SIZE-1:0]    j_busy_q, j_busy_d;
  logic [RS_SIZE-1:0]    k_busy_q, k_busy_d;
  logic [INSTR_ID_W-1:0] instr_id_q [RS_SIZE];
  logic [INSTR_ID_W-1:0] instr_id_d [RS_SIZE];
  logic [WORD_W-1:0]     imm_q [RS_SIZE];
  logic [WORD_W-1:0]     imm_d [RS_SIZE];
  logic [WORD_W-1:0]     pc_q [RS_SIZE];
  logic [WORD_W-1:0]     pc_d [RS_SIZE];
  logic [ROB_IDX_W-1:0]  rob_pos_q [RS_SIZE];
  logic [ROB_IDX_W-1:0]  rob_pos_d [RS_SIZE];
  logic [WORD_W-1:0]     vj_q [RS_SIZE];
  logic [WORD_W-1:0]     vj_d [RS_SIZE];
  logic [WORD_W-1:0]     vk_q [RS_SIZE];
  logic [WORD_W-1:0]     vk_d [RS_SIZE];
  logic [ROB_IDX_W-1:0]  qj_q [RS_SIZE];
  logic [ROB_IDX_W-1:0]  qj_d [RS_SIZE];
  logic [ROB_IDX_W-1:0]  qk_q [RS_SIZE];
  logic [ROB_IDX_W-1:0]  qk_d [RS_SIZE];

  // Issue output registers
  logic                  issue_en_q, issue_en_d;
  logic [INSTR_ID_W-1:0] out_instr_id_q, out_instr_id_d;
  logic [WORD_W-1:0]     out_imm_q, out_imm_d;
  logic [WORD_W-1:0]     out_rs1_q, out_rs1_d;
  logic [WORD_W-1:0]     out_rs2_q, out_rs2_d;
  logic [WORD_W-1:0]     out_pc_q, out_pc_d;
  logic [ROB_IDX_W-1:0]  out_rob_pos_q, out_rob_pos_d;

  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  logic               free_found, issue_found;

  assign ready_vec = valid_q & ~j_busy_q & ~k_busy_q;
  // All entries valid is the same as a valid count equal to RS_SIZE.
  assign full_out  = &valid_q;

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req_in    (~valid_q),
    .idx_out   (free_idx),
    .found_out (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_enc (
    .req_in    (ready_vec),
    .idx_out   (issue_idx),
    .found_out (issue_found)
  );

  // Next-state: flush beats everything; otherwise wakeup, issue and dispatch
  // all act on start-of-cycle state and touch disjoint entries.
  always_comb begin
    valid_d        = valid_q;
    j_busy_d       = j_busy_q;
    k_busy_d       = k_busy_q;
    instr_id_d     = instr_id_q;
    imm_d          = imm_q;
    pc_d           = pc_q;
    rob_pos_d      = rob_pos_q;
    vj_d           = vj_q;
    vk_d           = vk_q;
    qj_d           = qj_q;
    qk_d           = qk_q;
    issue_en_d     = 1'b0;
    out_instr_id_d = out_instr_id_q;
    out_imm_d      = out_imm_q;
    out_rs1_d      = out_rs1_q;
    out_rs2_d      = out_rs2_q;
    out_pc_d       = out_pc_q;
    out_rob_pos_d  = out_rob_pos_q;

    if (rdy_in) begin
      if (clear_in) begin
        valid_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (valid_q[i] && j_busy_q[i]) begin
            if (ex_cdb_en_in && (qj_q[i] == ex_cdb_rob_pos_in)) begin
              vj_d[i]     = ex_cdb_res_in;
              j_busy_d[i] = 1'b0;
            end else if (lsb_cdb_en_in && (qj_q[i] == lsb_cdb_rob_pos_in)) begin
              vj_d[i]     = lsb_cdb_res_in;
              j_busy_d[i] = 1'b0;
            end
          end
          if (valid_q[i] && k_busy_q[i]) begin
            if (ex_cdb_en_in && (qk_q[i] == ex_cdb_rob_pos_in)) begin
              vk_d[i]     = ex_cdb_res_in;
              k_busy_d[i] = 1'b0;
            end else if (lsb_cdb_en_in && (qk_q[i] == lsb_cdb_rob_pos_in)) begin
              vk_d[i]     = lsb_cdb_res_in;
              k_busy_d[i] = 1'b0;
            end
          end
        end

        if (issue_found) begin
          valid_d[issue_idx] = 1'b0;
          issue_en_d         = 1'b1;
          out_instr_id_d     = instr_id_q[issue_idx];
          out_imm_d          = imm_q[issue_idx];
          out_rs1_d          = vj_q[issue_idx];
          out_rs2_d          = vk_q[issue_idx];
          out_pc_d           = pc_q[issue_idx];
          out_rob_pos_d      = rob_pos_q[issue_idx];
        end

        if (disp_en_in && !full_out && free_found) begin
          valid_d[free_idx]    = 1'b1;
          instr_id_d[free_idx] = disp_instr_id_in;
          imm_d[free_idx]      = disp_imm_in;
          pc_d[free_idx]       = disp_pc_in;
          rob_pos_d[free_idx]  = disp_rob_pos_in;
          qj_d[free_idx]       = disp_qj_in;
          qk_d[free_idx]       = disp_qk_in;
          vj_d[free_idx]       = disp_vj_in;
          vk_d[free_idx]       = disp_vk_in;
          j_busy_d[free_idx]   = disp_j_busy_in;
          k_busy_d[free_idx]   = disp_k_busy_in;
          // Same-cycle broadcast bypass so the operand is not missed.
          if (disp_j_busy_in) begin
            if (ex_cdb_en_in && (disp_qj_in == ex_cdb_rob_pos_in)) begin
              vj_d[free_idx]     = ex_cdb_res_in;
              j_busy_d[free_idx] = 1'b0;
            end else if (lsb_cdb_en_in && (disp_qj_in == lsb_cdb_rob_pos_in)) begin
              vj_d[free_idx]     = lsb_cdb_res_in;
              j_busy_d[free_idx] = 1'b0;
            end
          end
          if (disp_k_busy_in) begin
            if (ex_cdb_en_in && (disp_qk_in == ex_cdb_rob_pos_in)) begin
              vk_d[free_idx]     = ex_cdb_res_in;
              k_busy_d[free_idx] = 1'b0;
            end else if (lsb_cdb_en_in && (disp_qk_in == lsb_cdb_rob_pos_in)) begin
              vk_d[free_idx]     = lsb_cdb_res_in;
              k_busy_d[free_idx] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Control state and issue outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q        <= '0;
      issue_en_q     <= 1'b0;
      out_instr_id_q <= '0;
      out_imm_q      <= '0;
      out_rs1_q      <= '0;
      out_rs2_q      <= '0;
      out_pc_q       <= '0;
      out_rob_pos_q  <= '0;
    end else begin
      valid_q        <= valid_d;
      issue_en_q     <= issue_en_d;
      out_instr_id_q <= out_instr_id_d;
      out_imm_q      <= out_imm_d;
      out_rs1_q      <= out_rs1_d;
      out_rs2_q      <= out_rs2_d;
      out_pc_q       <= out_pc_d;
      out_rob_pos_q  <= out_rob_pos_d;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    j_busy_q   <= j_busy_d;
    k_busy_q   <= k_busy_d;
    instr_id_q <= instr_id_d;
    imm_q      <= imm_d;
    pc_q       <= pc_d;
    rob_pos_q  <= rob_pos_d;
    vj_q       <= vj_d;
    vk_q       <= vk_d;
    qj_q       <= qj_d;
    qk_q       <= qk_d;
  end

  assign rs_to_ex_en_out = issue_en_q;
  assign ex_instr_id_out = out_instr_id_q;
  assign ex_imm_out      = out_imm_q;
  assign ex_rs1_out      = out_rs1_q;
  assign ex_rs2_out      = out_rs2_q;
  assign ex_pc_out       = out_pc_q;
  assign ex_rob_pos_out  = out_rob_pos_q;

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: directed scenarios plus randomized traffic against
// a behavioural model of the reservation station.
module tb_rs_scheduler;
  import rs_scheduler_pkg::*;

  localparam logic [INSTR_ID_W-1:0] ID_TAB [8] =
    '{ID_LUI, ID_AUIPC, ID_JAL, ID_JALR, ID_BEQ, ID_BNE, ID_ADDI, ID_ADD};

  logic                  clk_in = 1'b0;
  logic                  rst_n_in, rdy_in, clear_in, disp_en_in;
  logic [INSTR_ID_W-1:0] disp_instr_id_in;
  logic [WORD_W-1:0]     disp_imm_in, disp_pc_in, disp_vj_in, disp_vk_in;
  logic [ROB_IDX_W-1:0]  disp_rob_pos_in, disp_qj_in, disp_qk_in;
  logic                  disp_j_busy_in, disp_k_busy_in, full_out;
  logic                  ex_cdb_en_in, lsb_cdb_en_in;
  logic [ROB_IDX_W-1:0]  ex_cdb_rob_pos_in, lsb_cdb_rob_pos_in;
  logic [WORD_W-1:0]     ex_cdb_res_in, lsb_cdb_res_in;
  logic                  rs_to_ex_en_out;
  logic [INSTR_ID_W-1:0] ex_instr_id_out;
  logic [WORD_W-1:0]     ex_imm_out, ex_rs1_out, ex_rs2_out, ex_pc_out;
  logic [ROB_IDX_W-1:0]  ex_rob_pos_out;

  int tests_run    = 0;
  int tests_failed = 0;

  rs_scheduler dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_en_in(disp_en_in), .disp_instr_id_in(disp_instr_id_in),
    .disp_imm_in(disp_imm_in), .disp_pc_in(disp_pc_in),
    .disp_rob_pos_in(disp_rob_pos_in), .disp_vj_in(disp_vj_in),
    .disp_vk_in(disp_vk_in), .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in),
    .disp_j_busy_in(disp_j_busy_in), .disp_k_busy_in(disp_k_busy_in),
    .full_out(full_out),
    .ex_cdb_en_in(ex_cdb_en_in), .ex_cdb_rob_pos_in(ex_cdb_rob_pos_in),
    .ex_cdb_res_in(ex_cdb_res_in),
    .lsb_cdb_en_in(lsb_cdb_en_in), .lsb_cdb_rob_pos_in(lsb_cdb_rob_pos_in),
    .lsb_cdb_res_in(lsb_cdb_res_in),
    .rs_to_ex_en_out(rs_to_ex_en_out), .ex_instr_id_out(ex_instr_id_out),
    .ex_imm_out(ex_imm_out), .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out),
    .ex_pc_out(ex_pc_out), .ex_rob_pos_out(ex_rob_pos_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    bit                    v;
    logic [INSTR_ID_W-1:0] id;
    logic [WORD_W-1:0]     imm, pc, vj, vk;
    logic [ROB_IDX_W-1:0]  rob, qj, qk;
    bit                    jb, kb;
  } ent_t;

  ent_t                  m_rs [RS_SIZE];
  bit                    m_en;
  logic [INSTR_ID_W-1:0] m_o_id;
  logic [WORD_W-1:0]     m_o_imm, m_o_rs1, m_o_rs2, m_o_pc;
  logic [ROB_IDX_W-1:0]  m_o_rob;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < RS_SIZE; i++) if (m_rs[i].v) n++;
    return n;
  endfunction

  // Resolve one operand against the buses; EX has precedence.
  task automatic m_snoop(input logic [ROB_IDX_W-1:0] q, inout bit busy,
                         inout logic [WORD_W-1:0] val);
    if (!busy) return;
    if (ex_cdb_en_in && q == ex_cdb_rob_pos_in) begin
      val = ex_cdb_res_in; busy = 0;
    end else if (lsb_cdb_en_in && q == lsb_cdb_rob_pos_in) begin
      val = lsb_cdb_res_in; busy = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int   iss = -1;
    int   slot = -1;
    ent_t e;
    m_en = 0;
    if (!rdy_in) return;
    if (clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) m_rs[i].v = 0;
      return;
    end
    for (int i = 0; i < RS_SIZE; i++)
      if (iss < 0 && m_rs[i].v && !m_rs[i].jb && !m_rs[i].kb) iss = i;
    if (disp_en_in && m_count() < RS_SIZE)
      for (int i = 0; i < RS_SIZE; i++) if (slot < 0 && !m_rs[i].v) slot = i;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m_rs[i].v) begin
        m_snoop(m_rs[i].qj, m_rs[i].jb, m_rs[i].vj);
        m_snoop(m_rs[i].qk, m_rs[i].kb, m_rs[i].vk);
      end
    end
    if (iss >= 0) begin
      m_en = 1;
      m_o_id = m_rs[iss].id;   m_o_imm = m_rs[iss].imm; m_o_pc = m_rs[iss].pc;
      m_o_rs1 = m_rs[iss].vj;  m_o_rs2 = m_rs[iss].vk;  m_o_rob = m_rs[iss].rob;
      m_rs[iss].v = 0;
    end
    if (slot >= 0) begin
      e.v = 1; e.id = disp_instr_id_in; e.imm = disp_imm_in; e.pc = disp_pc_in;
      e.rob = disp_rob_pos_in; e.qj = disp_qj_in; e.qk = disp_qk_in;
      e.vj = disp_vj_in; e.vk = disp_vk_in;
      e.jb = disp_j_busy_in; e.kb = disp_k_busy_in;
      m_snoop(e.qj, e.jb, e.vj);
      m_snoop(e.qk, e.kb, e.vk);
      m_rs[slot] = e;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    clear_in = 0; disp_en_in = 0; disp_instr_id_in = '0; disp_imm_in = '0;
    disp_pc_in = '0; disp_rob_pos_in = '0; disp_vj_in = '0; disp_vk_in = '0;
    disp_qj_in = '0; disp_qk_in = '0; disp_j_busy_in = 0; disp_k_busy_in = 0;
    ex_cdb_en_in = 0; ex_cdb_rob_pos_in = '0; ex_cdb_res_in = '0;
    lsb_cdb_en_in = 0; lsb_cdb_rob_pos_in = '0; lsb_cdb_res_in = '0;
  endtask

  task automatic disp(input logic [INSTR_ID_W-1:0] id, input logic [WORD_W-1:0] vj,
                      input logic [WORD_W-1:0] vk, input logic [ROB_IDX_W-1:0] rob,
                      input logic [ROB_IDX_W-1:0] qj, input logic [ROB_IDX_W-1:0] qk,
                      input logic jb, input logic kb);
    disp_en_in = 1; disp_instr_id_in = id; disp_vj_in = vj; disp_vk_in = vk;
    disp_rob_pos_in = rob; disp_qj_in = qj; disp_qk_in = qk;
    disp_j_busy_in = jb; disp_k_busy_in = kb;
    disp_imm_in = 32'h100 + 32'(rob); disp_pc_in = 32'h1000 + 32'(rob) * 4;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n_in = 0; rdy_in = 1; idle();
    tick(); tick();
    tests_run++;
    if ({rs_to_ex_en_out, full_out, ex_rob_pos_out, ex_rs1_out, ex_rs2_out,
         ex_imm_out, ex_pc_out, ex_instr_id_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got en=%b full=%b rob=%h rs1=%h want all 0",
               rs_to_ex_en_out, full_out, ex_rob_pos_out, ex_rs1_out);
    end
    @(negedge clk_in); rst_n_in = 1;
    tick();
  endtask

  task automatic test_add_latency();
    idle(); disp(ID_ADD, 32'd5, 32'd7, 4'd3, 4'd0, 4'd0, 0, 0);
    tick(); idle();
    tests_run++;
    if (rs_to_ex_en_out !== 1'b0) begin
      tests_failed++; $display("FAIL add_cycle1_en got %b want 0", rs_to_ex_en_out);
    end
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rs1_out, ex_rs2_out, ex_rob_pos_out, ex_instr_id_out,
         ex_imm_out, ex_pc_out} !==
        {1'b1, 32'd5, 32'd7, 4'd3, ID_ADD, 32'h103, 32'h100c}) begin
      tests_failed++;
      $display("FAIL add_issue got en=%b rs1=%h rs2=%h rob=%h id=%h imm=%h pc=%h want 1/5/7/3/%h/103/100c",
               rs_to_ex_en_out, ex_rs1_out, ex_rs2_out, ex_rob_pos_out,
               ex_instr_id_out, ex_imm_out, ex_pc_out, ID_ADD);
    end
    tick();
    tests_run++;
    if (rs_to_ex_en_out !== 1'b0) begin
      tests_failed++; $display("FAIL add_cycle3_en got %b want 0", rs_to_ex_en_out);
    end
  endtask

  task automatic test_wakeup_ex();
    idle(); disp(ID_BEQ, 32'h0, 32'h20, 4'd8, 4'd2, 4'd0, 1, 0);
    tick(); idle();
    for (int c = 1; c <= 3; c++) begin
      tests_run++;
      if (rs_to_ex_en_out !== 1'b0) begin
        tests_failed++; $display("FAIL wake_wait_c%0d en got %b want 0", c, rs_to_ex_en_out);
      end
      tick();
    end
    ex_cdb_en_in = 1; ex_cdb_rob_pos_in = 4'd2; ex_cdb_res_in = 32'h10;
    tick(); idle();
    tests_run++;
    if (rs_to_ex_en_out !== 1'b0) begin
      tests_failed++; $display("FAIL wake_c5 en got %b want 0", rs_to_ex_en_out);
    end
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rs1_out, ex_rs2_out, ex_rob_pos_out} !==
        {1'b1, 32'h10, 32'h20, 4'd8}) begin
      tests_failed++;
      $display("FAIL wake_issue got en=%b rs1=%h rs2=%h rob=%h want 1/10/20/8",
               rs_to_ex_en_out, ex_rs1_out, ex_rs2_out, ex_rob_pos_out);
    end
  endtask

  task automatic test_dispatch_bypass();
    idle(); disp(ID_ADD, 32'h1, 32'h0, 4'd6, 4'd0, 4'd9, 0, 1);
    lsb_cdb_en_in = 1; lsb_cdb_rob_pos_in = 4'd9; lsb_cdb_res_in = 32'hABCD;
    tick(); idle();
    tests_run++;
    if (rs_to_ex_en_out !== 1'b0) begin
      tests_failed++; $display("FAIL bypass_c1 en got %b want 0", rs_to_ex_en_out);
    end
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rs2_out, ex_rob_pos_out} !== {1'b1, 32'hABCD, 4'd6}) begin
      tests_failed++;
      $display("FAIL bypass_issue got en=%b rs2=%h rob=%h want 1/abcd/6",
               rs_to_ex_en_out, ex_rs2_out, ex_rob_pos_out);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < RS_SIZE; i++) begin
      idle(); disp(ID_ADD, 32'(i), 32'(i), 4'(i), 4'(i + 8), 4'd0, 1, 0);
      tick();
      tests_run++;
      if (rs_to_ex_en_out !== 1'b0) begin
        tests_failed++; $display("FAIL fill_%0d en got %b want 0", i, rs_to_ex_en_out);
      end
    end
    idle();
    tests_run++;
    if (full_out !== 1'b1) begin
      tests_failed++; $display("FAIL full_after_fill got %b want 1", full_out);
    end
    disp(ID_ADD, 32'hDEAD, 32'hBEEF, 4'd15, 4'd0, 4'd0, 0, 0);  // must be dropped
    tick(); idle();
    ex_cdb_en_in = 1; ex_cdb_rob_pos_in = 4'd13; ex_cdb_res_in = 32'h55;
    tests_run++;
    if ({full_out, rs_to_ex_en_out} !== 2'b10) begin
      tests_failed++; $display("FAIL full_ignore got full=%b en=%b want 1/0", full_out, rs_to_ex_en_out);
    end
    tick(); idle();
    tests_run++;
    if ({full_out, rs_to_ex_en_out} !== 2'b10) begin
      tests_failed++; $display("FAIL full_no_credit got full=%b en=%b want 1/0", full_out, rs_to_ex_en_out);
    end
    tick();
    tests_run++;
    if ({full_out, rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out} !== {1'b0, 1'b1, 4'd5, 32'h55}) begin
      tests_failed++;
      $display("FAIL full_slot5_issue got full=%b en=%b rob=%h rs1=%h want 0/1/5/55",
               full_out, rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out);
    end
    disp(ID_ADDI, 32'h0, 32'h99, 4'd12, 4'd0, 4'd0, 1, 0);
    tick(); idle();
    tests_run++;
    if ({full_out, rs_to_ex_en_out} !== 2'b10) begin
      tests_failed++; $display("FAIL refill got full=%b en=%b want 1/0", full_out, rs_to_ex_en_out);
    end
    // Wake the refill (tag 0) and slot 6 (tag 14) together: slot 5 must win.
    ex_cdb_en_in = 1; ex_cdb_rob_pos_in = 4'd0; ex_cdb_res_in = 32'h31;
    lsb_cdb_en_in = 1; lsb_cdb_rob_pos_in = 4'd14; lsb_cdb_res_in = 32'h66;
    tick(); idle();
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out, ex_rs2_out} !== {1'b1, 4'd12, 32'h31, 32'h99}) begin
      tests_failed++;
      $display("FAIL refill_slot5_first got en=%b rob=%h rs1=%h rs2=%h want 1/c/31/99",
               rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out, ex_rs2_out);
    end
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out} !== {1'b1, 4'd6, 32'h66}) begin
      tests_failed++;
      $display("FAIL slot6_second got en=%b rob=%h rs1=%h want 1/6/66",
               rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (rs_to_ex_en_out !== 1'b0) begin
        tests_failed++; $display("FAIL full_tail_%0d en got %b want 0", c, rs_to_ex_en_out);
      end
    end
    clear_in = 1; tick(); idle();
    tests_run++;
    if (full_out !== 1'b0) begin
      tests_failed++; $display("FAIL full_after_clear got %b want 0", full_out);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      idle(); disp(ID_ADD, 32'h0, 32'h3, 4'(i), 4'd2, 4'd0, 1, 0);
      tick();
    end
    idle(); ex_cdb_en_in = 1; ex_cdb_rob_pos_in = 4'd2; ex_cdb_res_in = 32'h7;
    tick(); idle();
    clear_in = 1;  // all three entries are ready this cycle
    tick(); idle();
    tests_run++;
    if ({rs_to_ex_en_out, full_out} !== 2'b00) begin
      tests_failed++; $display("FAIL flush_now got en=%b full=%b want 0/0", rs_to_ex_en_out, full_out);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++;
      if (rs_to_ex_en_out !== 1'b0) begin
        tests_failed++; $display("FAIL flush_after_%0d en got %b want 0", c, rs_to_ex_en_out);
      end
    end
  endtask

  task automatic test_rdy_freeze();
    idle(); disp(ID_ADD, 32'h0, 32'hA1, 4'd1, 4'd4, 4'd0, 1, 0); tick();
    idle(); disp(ID_ADD, 32'h0, 32'hA2, 4'd2, 4'd4, 4'd0, 1, 0); tick();
    idle(); ex_cdb_en_in = 1; ex_cdb_rob_pos_in = 4'd4; ex_cdb_res_in = 32'h44; tick();
    // Both entries ready now; everything below must be ignored while frozen.
    idle(); rdy_in = 0; clear_in = 1;
    disp(ID_ADD, 32'h9, 32'h9, 4'd9, 4'd0, 4'd0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (rs_to_ex_en_out !== 1'b0) begin
        tests_failed++; $display("FAIL frozen_%0d en got %b want 0", c, rs_to_ex_en_out);
      end
    end
    idle(); rdy_in = 1;
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out, ex_rs2_out} !== {1'b1, 4'd1, 32'h44, 32'hA1}) begin
      tests_failed++;
      $display("FAIL resume_first got en=%b rob=%h rs1=%h rs2=%h want 1/1/44/a1",
               rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out, ex_rs2_out);
    end
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rob_pos_out} !== {1'b1, 4'd2}) begin
      tests_failed++; $display("FAIL resume_second got en=%b rob=%h want 1/2", rs_to_ex_en_out, ex_rob_pos_out);
    end
    tick();
    tests_run++;
    if ({rs_to_ex_en_out, full_out} !== 2'b00) begin
      tests_failed++; $display("FAIL resume_done got en=%b full=%b want 0/0", rs_to_ex_en_out, full_out);
    end
  endtask

  task automatic test_random();
    idle(); rdy_in = 1; clear_in = 1; tick(); idle();
    for (int i = 0; i < RS_SIZE; i++) m_rs[i].v = 0;
    m_en = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy_in             = ($urandom_range(0, 9) != 0);
      clear_in           = ($urandom_range(0, 49) == 0);
      disp_en_in         = ($urandom_range(0, 2) != 0);
      disp_instr_id_in   = ID_TAB[$urandom_range(0, 7)];
      disp_imm_in        = $urandom;
      disp_pc_in         = $urandom;
      disp_rob_pos_in    = ROB_IDX_W'($urandom);
      disp_vj_in         = $urandom;
      disp_vk_in         = $urandom;
      disp_qj_in         = ROB_IDX_W'($urandom);
      disp_qk_in         = ROB_IDX_W'($urandom);
      disp_j_busy_in     = ($urandom_range(0, 2) == 0);
      disp_k_busy_in     = ($urandom_range(0, 2) == 0);
      ex_cdb_en_in       = ($urandom_range(0, 2) != 0);
      ex_cdb_rob_pos_in  = ROB_IDX_W'($urandom);
      ex_cdb_res_in      = $urandom;
      lsb_cdb_en_in      = ($urandom_range(0, 2) != 0);
      lsb_cdb_rob_pos_in = ROB_IDX_W'($urandom);
      lsb_cdb_res_in     = $urandom;
      tests_run++;
      if (full_out !== (m_count() == RS_SIZE)) begin
        tests_failed++;
        $display("FAIL rand_full cyc=%0d got %b want %b", cyc, full_out, m_count() == RS_SIZE);
      end
      model_step();
      tick();
      tests_run++;
      if (rs_to_ex_en_out !== m_en) begin
        tests_failed++; $display("FAIL rand_en cyc=%0d got %b want %b", cyc, rs_to_ex_en_out, m_en);
      end else if (m_en && ({ex_instr_id_out, ex_imm_out, ex_rs1_out, ex_rs2_out, ex_pc_out, ex_rob_pos_out} !==
                            {m_o_id, m_o_imm, m_o_rs1, m_o_rs2, m_o_pc, m_o_rob})) begin
        tests_failed++;
        $display("FAIL rand_issue cyc=%0d got rob=%h rs1=%h rs2=%h id=%h want rob=%h rs1=%h rs2=%h id=%h",
                 cyc, ex_rob_pos_out, ex_rs1_out, ex_rs2_out, ex_instr_id_out,
                 m_o_rob, m_o_rs1, m_o_rs2, m_o_id);
      end
    end
    idle(); rdy_in = 1; clear_in = 1; tick(); idle();
  endtask

  task automatic test_async_reset();
    idle(); disp(ID_ADD, 32'h11, 32'h22, 4'd4, 4'd0, 4'd0, 0, 0);
    tick(); idle();
    disp(ID_ADD, 32'h33, 32'h44, 4'd5, 4'd7, 4'd0, 1, 0);
    tick(); idle();
    tests_run++;
    if ({rs_to_ex_en_out, ex_rob_pos_out} !== {1'b1, 4'd4}) begin
      tests_failed++; $display("FAIL pre_reset_issue got en=%b rob=%h want 1/4", rs_to_ex_en_out, ex_rob_pos_out);
    end
    #2 rst_n_in = 0;
    #1;
    tests_run++;
    if ({rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out, ex_rs2_out, full_out} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset got en=%b rob=%h rs1=%h rs2=%h full=%b want all 0",
               rs_to_ex_en_out, ex_rob_pos_out, ex_rs1_out, ex_rs2_out, full_out);
    end
    @(negedge clk_in); rst_n_in = 1;
    // The busy entry was discarded, so waking its tag must not issue anything.
    ex_cdb_en_in = 1; ex_cdb_rob_pos_in = 4'd7; ex_cdb_res_in = 32'h1;
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (rs_to_ex_en_out !== 1'b0) begin
        tests_failed++; $display("FAIL post_reset_%0d en got %b want 0", c, rs_to_ex_en_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_wakeup_ex();
    test_dispatch_bypass();
    test_full();
    test_flush();
    test_rdy_freeze();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
